// File: rtl/wb_ctrl.sv
// rtl/wb_ctrl.sv - writeback controller merging ALU results and memory loads into one register-file write port
//
// Purpose: produces a single registered register-file write (rf_wr_en, rf_wr_addr, rf_dat)
// from single-cycle ALU results and variable-latency loads. A one-entry skid buffer absorbs
// an ALU result that collides with a load write, a one-entry pending-load scoreboard raises
// stall on RAW/WAW hazards, and a wait timer retires a load that the memory never answers.
//
// Ports:
//   clk         clock, all state updates on posedge
//   reset       synchronous, active-high reset
//   alu_valid   ALU result present this cycle
//   alu_dest    ALU destination register (pw+1 bits)
//   alu_data    ALU result (DW bits)
//   ld_issue    load issued this cycle
//   ld_dest     load destination register (pw+1 bits)
//   mem_rdy     memory load data valid
//   mem_data    memory load data (DW bits)
//   chk_addrA   decode read pointer A, hazard check
//   chk_addrB   decode read pointer B, hazard check
//   rf_wr_en    register-file write enable, registered
//   rf_wr_addr  register-file write address, registered
//   rf_dat      register-file write data, registered
//   stall       combinational; upstream holds and inputs are ignored while high
//   ld_timeout  sticky memory-timeout flag, registered
module wb_ctrl #(
  parameter int pw  = 4,
  parameter int DW  = 8,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [pw:0]   alu_dest,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_issue,
  input  logic [pw:0]   ld_dest,
  input  logic          mem_rdy,
  input  logic [DW-1:0] mem_data,
  input  logic [pw:0]   chk_addrA,
  input  logic [pw:0]   chk_addrB,
  output logic          rf_wr_en,
  output logic [pw:0]   rf_wr_addr,
  output logic [DW-1:0] rf_dat,
  output logic          stall,
  output logic          ld_timeout
);

  localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;

  typedef enum logic {IDLE, LD_WAIT} state_t;

  state_t        state, state_nx;
  logic          pend_valid, pend_valid_nx;
  logic [pw:0]   pend_dest, pend_dest_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          skid_valid, skid_valid_nx;
  logic [pw:0]   skid_dest, skid_dest_nx;
  logic [DW-1:0] skid_data, skid_data_nx;

  logic          ld_wr;
  logic [DW-1:0] ld_wr_data;
  logic          tmo_hit;
  logic          alu_acc, ld_acc;
  logic          wr_en_nx;
  logic [pw:0]   wr_addr_nx;
  logic [DW-1:0] wr_data_nx;

  // A write still on the port has not been committed by the register file yet,
  // so a reader of that address must wait one more cycle.
  assign stall = skid_valid
               || (rf_wr_en && (chk_addrA == rf_wr_addr || chk_addrB == rf_wr_addr))
               || (pend_valid && (chk_addrA == pend_dest || chk_addrB == pend_dest
                                  || ld_issue || (alu_valid && alu_dest == pend_dest)));

  assign alu_acc = alu_valid && !stall;
  assign ld_acc  = ld_issue && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_dest  <= '0;
      timer      <= '0;
      skid_valid <= 1'b0;
      skid_dest  <= '0;
      skid_data  <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_dat     <= '0;
      ld_timeout <= 1'b0;
    end else begin
      state      <= state_nx;
      pend_valid <= pend_valid_nx;
      pend_dest  <= pend_dest_nx;
      timer      <= timer_nx;
      skid_valid <= skid_valid_nx;
      skid_dest  <= skid_dest_nx;
      skid_data  <= skid_data_nx;
      rf_wr_en   <= wr_en_nx;
      rf_wr_addr <= wr_addr_nx;
      rf_dat     <= wr_data_nx;
      ld_timeout <= ld_timeout | tmo_hit;
    end
  end

  // Load FSM: mem_rdy is only meaningful while a load is outstanding, and it
  // takes precedence over the timeout in the final wait cycle.
  always_comb begin
    state_nx      = state;
    pend_valid_nx = pend_valid;
    pend_dest_nx  = pend_dest;
    timer_nx      = timer;
    ld_wr         = 1'b0;
    ld_wr_data    = '0;
    tmo_hit       = 1'b0;
    case (state)
      IDLE: begin
        if (ld_acc) begin
          pend_valid_nx = 1'b1;
          pend_dest_nx  = ld_dest;
          timer_nx      = '0;
          state_nx      = LD_WAIT;
        end
      end
      LD_WAIT: begin
        if (mem_rdy) begin
          ld_wr         = 1'b1;
          ld_wr_data    = mem_data;
          pend_valid_nx = 1'b0;
          state_nx      = IDLE;
        end else if (timer == TW'(TMO)) begin
          ld_wr         = 1'b1;
          tmo_hit       = 1'b1;
          pend_valid_nx = 1'b0;
          state_nx      = IDLE;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Write-port arbitration: load > skid > ALU. A skid entry always stalls
  // upstream, so an ALU result can never be accepted while the skid drains.
  always_comb begin
    wr_en_nx      = 1'b0;
    wr_addr_nx    = rf_wr_addr;
    wr_data_nx    = rf_dat;
    skid_valid_nx = skid_valid;
    skid_dest_nx  = skid_dest;
    skid_data_nx  = skid_data;
    if (ld_wr) begin
      wr_en_nx   = 1'b1;
      wr_addr_nx = pend_dest;
      wr_data_nx = ld_wr_data;
      if (alu_acc) begin
        skid_valid_nx = 1'b1;
        skid_dest_nx  = alu_dest;
        skid_data_nx  = alu_data;
      end
    end else if (skid_valid) begin
      wr_en_nx      = 1'b1;
      wr_addr_nx    = skid_dest;
      wr_data_nx    = skid_data;
      skid_valid_nx = 1'b0;
    end else if (alu_acc) begin
      wr_en_nx   = 1'b1;
      wr_addr_nx = alu_dest;
      wr_data_nx = alu_data;
    end
  end

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
Writeback controller directly upstream of the 8-bit register file. It merges single-cycle ALU results with variable-latency data-memory loads into one registered write port: write enable, write address and write data. A one-entry skid buffer absorbs ALU/load collisions. A pending-load scoreboard generates stall for RAW/WAW hazards, and a timeout counter guards against a memory that never responds.

Parameters:
pw, 4, register address pointer parameter; address ports are pw+1 bits wide, matching the register file write/read pointers
DW, 8, data width
TMO, 15, last wait-counter value at which mem_rdy is still accepted before timeout

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU result present this cycle
alu_dest  input  pw+1  ALU destination register
alu_data  input  DW  ALU result
ld_issue  input  1  load issued this cycle
ld_dest  input  pw+1  load destination register
mem_rdy  input  1  memory load data valid
mem_data  input  DW  memory load data
chk_addrA  input  pw+1  decode read pointer A, hazard check
chk_addrB  input  pw+1  decode read pointer B, hazard check
rf_wr_en  output  1  register-file write enable, registered
rf_wr_addr  output  pw+1  register-file write address, registered
rf_dat  output  DW  register-file write data, registered
stall  output  1  combinational; upstream holds, and inputs are ignored, while high
ld_timeout  output  1  sticky memory-timeout flag, registered

Behaviour:
- Reset (sync, active-high): state IDLE; skid empty; pend_valid=0; timer=0; rf_wr_en=0; rf_wr_addr=0; rf_dat=0; ld_timeout=0. Reset mid-LD_WAIT drops the pending load with no write; a later mem_rdy is ignored.
- Acceptance: ALU accepted when alu_valid && !stall. Load accepted when ld_issue && !stall.
- Stall is high when any of the following holds:
  - skid full
  - rf_wr_en && (chk_addrA==rf_wr_addr || chk_addrB==rf_wr_addr)
  - pend_valid && (chk_addrA==pend_dest || chk_addrB==pend_dest || ld_issue || (alu_valid && alu_dest==pend_dest))
- FSM, two states:
  - IDLE: accepted load latches pend_dest=ld_dest, pend_valid=1, timer=0, next state LD_WAIT. mem_rdy is ignored in IDLE.
  - LD_WAIT, mem_rdy=1: load write is scheduled (pend_dest, mem_data); next state IDLE; pend_valid clears.
  - LD_WAIT, mem_rdy=0 and timer<TMO: timer increments.
  - LD_WAIT, mem_rdy=0 and timer==TMO: timeout. Schedule write (pend_dest, 0x00), set ld_timeout, next state IDLE.
  - mem_rdy in the same cycle as the timeout condition wins: real data is written and ld_timeout is not set.
- Timer width: clog2(TMO+1).
- Write priority per cycle: load write > skid entry > accepted ALU.
  - Load write with a simultaneous accepted ALU: ALU (dest, data) goes into the skid, which drains on the next cycle.
  - Skid drains in any cycle with no load write.
- Latency: the winning write appears on rf_wr_en/rf_wr_addr/rf_dat exactly 1 cycle after the source event; rf_wr_en is high for exactly 1 cycle per write. The register file commits on the following edge. With no write, rf_wr_en=0 and addr/data hold their last values.
- Writes to address 0 are passed through unchanged.
- ld_timeout is cleared only by reset.
- Accepted ALU and load in the same IDLE cycle: both are accepted; the ALU write proceeds normally.

Test Plan:
1. IDLE, alu_valid=1, dest=3, data=0x5A at cycle N -> cycle N+1: rf_wr_en=1, rf_wr_addr=3, rf_dat=0x5A. Cycle N+2: rf_wr_en=0. stall=0 throughout (chk addrs ≠ 3).
2. ld_issue, dest=7 at cycle 0; chk_addrA=7 on cycles 1-3; mem_rdy=1 with data 0xC3 at cycle 3 -> stall=1 on cycles 1-3; cycle 4 writes 7/0xC3; stall still 1 on cycle 4 (in-flight match), 0 on cycle 5.
3. LD_WAIT with dest=2; cycle N: mem_rdy=1, data 0x22, plus alu_valid dest=4, data 0x11 -> N+1 writes 2/0x22 with stall=1; N+2 writes 4/0x11; stall=0 at N+2.
4. TMO=15, ld_issue dest=9 at cycle 0, mem_rdy never asserted -> cycle 17: rf_wr_en=1, addr 9, data 0x00, ld_timeout=1 and it stays 1. A mem_rdy at cycle 16 instead -> real data written at cycle 17, ld_timeout=0.
5. ld_issue dest=6 at cycle 0; reset=1 at cycle 2; mem_rdy=1 with data 0xFF at cycle 3 -> no write ever; state IDLE; stall=0; all outputs 0 after reset.
6. Pending load dest=5; alu_valid dest=5, data 0x33 held -> stall=1 until the load data is written; the ALU write of 5/0x33 lands one cycle after the load write.
